// File: rtl/bus_timer_pkg.sv
// Shared register map, CTRL bit positions and reset constants for the bus timer.
// Latency: n/a (types, constants and a byte-merge helper only).
// Backpressure: n/a.
package bus_timer_pkg;

    typedef enum logic [2:0] {
        TMR_CTRL     = 3'd0,
        TMR_PRESCALE = 3'd1,
        TMR_COUNT_LO = 3'd2,
        TMR_COUNT_HI = 3'd3,
        TMR_CMP_LO   = 3'd4,
        TMR_CMP_HI   = 3'd5,
        TMR_STATUS   = 3'd6,
        TMR_RSVD     = 3'd7
    } tmr_reg_e;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_PERIODIC = 2;

    // Compare resets to all-ones so nothing fires before software programs it.
    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// System-bus slave port of the timer: access strobe, direction, address, write data/mask, read data.
// Latency: read data returns one cycle after the access is sampled.
// Backpressure: none; the slave accepts one access per cycle.
interface bus_timer_if;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [3:0]  system_bus_mask;
    logic [31:0] system_bus_rd_data;

    modport master (
        output system_bus_en, system_bus_rdwr, system_bus_addr,
               system_bus_wr_data, system_bus_mask,
        input  system_bus_rd_data
    );

    modport slave (
        input  system_bus_en, system_bus_rdwr, system_bus_addr,
               system_bus_wr_data, system_bus_mask,
        output system_bus_rd_data
    );
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..limit while enabled and emits a one-cycle tick on the limit value.
// Latency: tick is combinational from the registered count; limit = 0 ticks every enabled cycle.
// Backpressure: none; clr restarts the count from 0 and en = 0 holds it.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tick
);
    logic [W-1:0] cnt;

    assign tick = en && (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (tick) cnt <= '0;
        else if (en)   cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit timer with prescaler, compare and level IRQ; BUS_TIMER_PERIODIC_EN adds auto-reload.
// Latency: writes take effect at the sampling edge; read data is registered (one cycle).
// Backpressure: none; single-cycle accesses are accepted back-to-back.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    bus_timer_if.slave bus,
    output logic       timer_irq
);
    tmr_reg_e              off;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ctrl_enable;
    logic                  ctrl_irq_en;
    logic                  ctrl_periodic;
    logic [PRESCALE_W-1:0] prescale;
    logic [63:0]           count;
    logic [63:0]           count_nxt;
    logic [63:0]           cmp;
    logic [31:0]           shadow;
    logic [31:0]           rd_mux;
    logic                  pending;
    logic                  pending_set;
    logic                  status_clr;
    logic                  tick;
    logic                  wrap;
    logic                  unused_addr;

    assign off         = tmr_reg_e'(bus.system_bus_addr[4:2]);
    assign wr_en       = bus.system_bus_en & bus.system_bus_rdwr;
    assign rd_en       = bus.system_bus_en & ~bus.system_bus_rdwr;
    assign unused_addr = ^{bus.system_bus_addr[31:5], bus.system_bus_addr[1:0]};
    assign status_clr  = wr_en && (off == TMR_STATUS) && bus.system_bus_mask[0]
                         && bus.system_bus_wr_data[0];

    timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_enable),
        .clr   (wr_en && (off == TMR_PRESCALE)),
        .limit (prescale),
        .tick  (tick)
    );

`ifdef BUS_TIMER_PERIODIC_EN
    // Periodic mode reloads on the matching tick and ignores the >= compare.
    assign wrap        = tick & ctrl_periodic & (count == cmp);
    assign pending_set = ctrl_periodic ? wrap : (count >= cmp);

    always_ff @(posedge clk) begin
        if (rst)
            ctrl_periodic <= 1'b0;
        else if (wr_en && (off == TMR_CTRL) && bus.system_bus_mask[0])
            ctrl_periodic <= bus.system_bus_wr_data[CTRL_PERIODIC];
    end
`else
    assign ctrl_periodic = 1'b0;
    assign wrap          = 1'b0;
    assign pending_set   = count >= cmp;
`endif

    // A bus write to COUNT beats a same-cycle tick or reload.
    always_comb begin
        count_nxt = count;
        if (wr_en && (off == TMR_COUNT_LO))
            count_nxt[31:0] = merge_bytes(count[31:0], bus.system_bus_wr_data, bus.system_bus_mask);
        else if (wr_en && (off == TMR_COUNT_HI))
            count_nxt[63:32] = merge_bytes(count[63:32], bus.system_bus_wr_data, bus.system_bus_mask);
        else if (wrap)
            count_nxt = '0;
        else if (tick)
            count_nxt = count + 64'd1;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            TMR_CTRL: begin
                rd_mux[CTRL_ENABLE]   = ctrl_enable;
                rd_mux[CTRL_IRQ_EN]   = ctrl_irq_en;
                rd_mux[CTRL_PERIODIC] = ctrl_periodic;
            end
            TMR_PRESCALE: rd_mux    = 32'(prescale);
            TMR_COUNT_LO: rd_mux    = count[31:0];
            TMR_COUNT_HI: rd_mux    = shadow;
            TMR_CMP_LO:   rd_mux    = cmp[31:0];
            TMR_CMP_HI:   rd_mux    = cmp[63:32];
            TMR_STATUS:   rd_mux[0] = pending;
            default:      rd_mux    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_enable            <= 1'b0;
            ctrl_irq_en            <= 1'b0;
            prescale               <= '0;
            count                  <= '0;
            cmp                    <= CMP_RESET;
            shadow                 <= '0;
            pending                <= 1'b0;
            bus.system_bus_rd_data <= '0;
        end else begin
            count   <= count_nxt;
            pending <= pending_set | (pending & ~status_clr);
            if (wr_en) begin
                case (off)
                    TMR_CTRL: begin
                        if (bus.system_bus_mask[0]) begin
                            ctrl_enable <= bus.system_bus_wr_data[CTRL_ENABLE];
                            ctrl_irq_en <= bus.system_bus_wr_data[CTRL_IRQ_EN];
                        end
                    end
                    TMR_PRESCALE: prescale <= PRESCALE_W'(merge_bytes(32'(prescale),
                                                  bus.system_bus_wr_data, bus.system_bus_mask));
                    TMR_CMP_LO:   cmp[31:0] <= merge_bytes(cmp[31:0],
                                                  bus.system_bus_wr_data, bus.system_bus_mask);
                    TMR_CMP_HI:   cmp[63:32] <= merge_bytes(cmp[63:32],
                                                  bus.system_bus_wr_data, bus.system_bus_mask);
                    default: ;
                endcase
            end
            // Reading LO freezes HI so a LO/HI pair is coherent across a carry.
            if (rd_en) begin
                bus.system_bus_rd_data <= rd_mux;
                if (off == TMR_COUNT_LO) shadow <= count[63:32];
            end
        end
    end

    assign timer_irq = pending & ctrl_irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized self-checking bench for bus_timer; expectations come from elapsed-cycle arithmetic.
// Accesses are driven and sampled on the falling edge.
module tb_bus_timer;
    import bus_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irq;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_at = 0;

    bus_timer_if bus ();

    bus_timer #(.PRESCALE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input tmr_reg_e off);
        return 32'hA000_0000 | (32'(off) << 2);
    endfunction

    task automatic wr_m(input tmr_reg_e off, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.system_bus_en      = 1'b1;
        bus.system_bus_rdwr    = 1'b1;
        bus.system_bus_addr    = addr_of(off);
        bus.system_bus_wr_data = d;
        bus.system_bus_mask    = m;
        @(negedge clk);
        bus.system_bus_en      = 1'b0;
        bus.system_bus_rdwr    = 1'b0;
        last_at = cyc;
    endtask

    task automatic wr(input tmr_reg_e off, input logic [31:0] d);
        wr_m(off, d, 4'hF);
    endtask

    task automatic rd(input tmr_reg_e off, output logic [31:0] d);
        @(negedge clk);
        bus.system_bus_en   = 1'b1;
        bus.system_bus_rdwr = 1'b0;
        bus.system_bus_addr = addr_of(off);
        @(negedge clk);
        bus.system_bus_en   = 1'b0;
        last_at = cyc;
        d = bus.system_bus_rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d, base, dat, bm;
        logic [31:0] exp_rst [8];
        logic [63:0] model;
        logic [3:0]  m;
        int e_at, r_at, p, n, c, frozen;

        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        bus.system_bus_en      = 1'b0;
        bus.system_bus_rdwr    = 1'b0;
        bus.system_bus_addr    = '0;
        bus.system_bus_wr_data = '0;
        bus.system_bus_mask    = '0;

        // Reset values of every offset.
        do_reset();
        check("rst_irq", timer_irq, 0);
        check("rst_rd_data", bus.system_bus_rd_data, 0);
        for (int i = 0; i < 8; i++) begin
            rd(tmr_reg_e'(3'(i)), d);
            check($sformatf("rst_reg%0d", i), d, exp_rst[i]);
        end

        // Prescaled counting: count = enabled cycles / (P+1), then frozen when disabled.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            p = (it == 0) ? 3 : int'($urandom_range(0, 5));
            wr(TMR_PRESCALE, 32'(p));
            wr(TMR_CTRL, 32'h1);
            e_at = last_at;
            n = (it == 0) ? 40 : int'($urandom_range(10, 40));
            repeat (n) @(negedge clk);
            rd(TMR_COUNT_LO, d);
            check("presc_count", d, 64'((last_at - 1 - e_at) / (p + 1)));
            wr(TMR_CTRL, 32'h0);
            frozen = (last_at - e_at) / (p + 1);
            rd(TMR_COUNT_LO, d);
            check("presc_frozen_a", d, 64'(frozen));
            repeat (20) @(negedge clk);
            rd(TMR_COUNT_LO, d);
            check("presc_frozen_b", d, 64'(frozen));
            rd(TMR_PRESCALE, d);
            check("presc_reg", d, 64'(p));
        end

        // One-shot IRQ one cycle after COUNT reaches CMP; W1C loses to a live set condition.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            c = int'($urandom_range(3, 10));
            wr(TMR_CMP_LO, 32'(c));
            wr(TMR_CMP_HI, 32'h0);
            wr(TMR_PRESCALE, 32'h0);
            wr(TMR_CTRL, 32'h3);
            e_at = last_at;
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                check("oneshot_irq", timer_irq, 64'(cyc >= e_at + c + 1));
            end
            wr(TMR_STATUS, 32'h1);
            check("oneshot_reset_wins", timer_irq, 1);
            rd(TMR_STATUS, d);
            check("oneshot_status", d, 1);
            wr(TMR_CMP_LO, 32'd100);
            wr(TMR_STATUS, 32'h1);
            check("oneshot_cleared", timer_irq, 0);
            rd(TMR_STATUS, d);
            check("oneshot_status_clr", d, 0);
        end

        // Snapshot: HI returns the value captured by the last LO read.
        do_reset();
        wr(TMR_COUNT_LO, 32'hFFFF_FFFE);
        wr(TMR_COUNT_HI, 32'h1);
        wr(TMR_PRESCALE, 32'h0);
        wr(TMR_CTRL, 32'h1);
        e_at = last_at;
        rd(TMR_COUNT_LO, d);
        model = 64'h1_FFFF_FFFE + 64'(last_at - 1 - e_at);
        check("snap_lo", d, 64'(model[31:0]));
        repeat (2) @(negedge clk);
        rd(TMR_COUNT_HI, d);
        check("snap_hi_shadow", d, 64'(model[63:32]));
        wr(TMR_CMP_HI, 32'h5);
        check("snap_rd_hold", bus.system_bus_rd_data, 64'(model[63:32]));
        rd(TMR_COUNT_LO, d);
        model = 64'h1_FFFF_FFFE + 64'(last_at - 1 - e_at);
        rd(TMR_COUNT_HI, d);
        check("snap_hi_live", d, 64'(model[63:32]));

        // Byte-lane masking on COUNT_LO and CMP_HI.
        do_reset();
        for (int it = 0; it < 6; it++) begin
            base = (it == 0) ? 32'h1234_5678 : $urandom;
            dat  = (it == 0) ? 32'h0000_AB00 : $urandom;
            m    = (it == 0) ? 4'b0010 : 4'($urandom_range(0, 15));
            bm   = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
            wr(it[0] ? TMR_CMP_HI : TMR_COUNT_LO, base);
            wr_m(it[0] ? TMR_CMP_HI : TMR_COUNT_LO, dat, m);
            rd(it[0] ? TMR_CMP_HI : TMR_COUNT_LO, d);
            check("mask_merge", d, 64'((dat & bm) | (base & ~bm)));
        end
        dat = $urandom;
        wr(TMR_RSVD, dat);
        rd(TMR_RSVD, d);
        check("rsvd_zero", d, 0);

        // A COUNT write that coincides with a tick is kept without increment.
        do_reset();
        wr(TMR_PRESCALE, 32'h0);
        wr(TMR_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        dat = $urandom;
        wr(TMR_COUNT_LO, dat);
        e_at = last_at;
        rd(TMR_COUNT_LO, d);
        check("wr_beats_tick", d, 64'(dat + 32'(last_at - 1 - e_at)));

        // Reset in the middle of counting.
        wr(TMR_CMP_LO, 32'h0);
        wr(TMR_CTRL, 32'h3);
        do_reset();
        check("midrst_irq", timer_irq, 0);
        rd(TMR_COUNT_LO, d);
        check("midrst_count", d, 0);
        rd(TMR_CMP_LO, d);
        check("midrst_cmp", d, 32'hFFFF_FFFF);

`ifdef BUS_TIMER_PERIODIC_EN
        // Periodic: COUNT cycles 0..CMP and PENDING sets at the first reload.
        do_reset();
        c = int'($urandom_range(1, 4));
        wr(TMR_CMP_LO, 32'(c));
        wr(TMR_CMP_HI, 32'h0);
        wr(TMR_PRESCALE, 32'h0);
        wr(TMR_CTRL, 32'h7);
        e_at = last_at;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("periodic_irq", timer_irq, 64'(cyc >= e_at + c + 1));
        end
        for (int k = 0; k < 4; k++) begin
            rd(TMR_COUNT_LO, d);
            check("periodic_count", d, 64'((last_at - 1 - e_at) % (c + 1)));
        end
        rd(TMR_CTRL, d);
        check("periodic_ctrl", d, 7);
`else
        do_reset();
        wr(TMR_CTRL, 32'h7);
        rd(TMR_CTRL, d);
        check("ctrl_no_periodic", d, 3);
        wr_m(TMR_CTRL, 32'h0, 4'b1110);
        rd(TMR_CTRL, d);
        check("ctrl_mask", d, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
